// File: rtl/hyperbus_cfg_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hyperbus_cfg_seq_pkg
//  Purpose  : Shared types and helpers for the HyperBus configuration
//             sequencer (state encoding, table index width).
//  Revision : 1.0 - initial release
// ============================================================================
package hyperbus_cfg_seq_pkg;

  localparam int unsigned StateWidth = 3;

  // Sequencer states; VERIFY is only reachable in the read-back build.
  typedef enum logic [StateWidth-1:0] {
    CFG_DELAY  = 3'd0,
    CFG_WRITE  = 3'd1,
    CFG_VERIFY = 3'd2,
    CFG_DONE   = 3'd3,
    CFG_ERR    = 3'd4
  } cfg_state_e;

  // Width of the table index; a single-entry table still needs one bit.
  function automatic int unsigned idx_width(input int unsigned num_entries);
    return (num_entries > 1) ? $clog2(num_entries) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hyperbus_cfg_seq_mux.sv
`default_nettype none
// ============================================================================
//  Module   : hyperbus_cfg_seq_mux
//  Purpose  : Combinational register-bus steering. In pass-through the host
//             bus is wired straight to the device bus; otherwise the
//             sequencer owns the device bus and the host is stalled.
//  Revision : 1.0 - initial release
// ============================================================================
module hyperbus_cfg_seq_mux #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
) (
  input  logic                   pass_thru,
  // sequencer-side request (registered upstream)
  input  logic                   seq_valid,
  input  logic                   seq_write,
  input  logic [AddrWidth-1:0]   seq_addr,
  input  logic [DataWidth-1:0]   seq_wdata,
  // host side
  input  logic [AddrWidth-1:0]   host_addr,
  input  logic                   host_write,
  input  logic [DataWidth-1:0]   host_wdata,
  input  logic [DataWidth/8-1:0] host_wstrb,
  input  logic                   host_valid,
  output logic [DataWidth-1:0]   host_rdata,
  output logic                   host_ready,
  output logic                   host_error,
  // device side
  output logic [AddrWidth-1:0]   dev_addr,
  output logic                   dev_write,
  output logic [DataWidth-1:0]   dev_wdata,
  output logic [DataWidth/8-1:0] dev_wstrb,
  output logic                   dev_valid,
  input  logic [DataWidth-1:0]   dev_rdata,
  input  logic                   dev_ready,
  input  logic                   dev_error
);

  // Select the device-bus owner and steer the response back to the host only
  // when the host owns the bus.
  always_comb begin
    dev_addr   = seq_addr;
    dev_write  = seq_write;
    dev_wdata  = seq_wdata;
    dev_wstrb  = '1;
    dev_valid  = seq_valid;
    host_rdata = '0;
    host_ready = 1'b0;
    host_error = 1'b0;
    if (pass_thru) begin
      dev_addr   = host_addr;
      dev_write  = host_write;
      dev_wdata  = host_wdata;
      dev_wstrb  = host_wstrb;
      dev_valid  = host_valid;
      host_rdata = dev_rdata;
      host_ready = dev_ready;
      host_error = dev_error;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hyperbus_cfg_seq.sv
`default_nettype none
// ============================================================================
//  Module   : hyperbus_cfg_seq
//  Purpose  : Post-reset configuration sequencer for the HyperBus controller
//             register file. Writes a compile-time (address, data) table into
//             the controller after reset or on start_i, stalling host traffic
//             meanwhile; transparent pass-through once finished.
//             Define HYPERBUS_CFG_SEQ_VERIFY_EN to read back and compare each
//             entry after it is written.
//  Revision : 1.0 - initial release
// ============================================================================
module hyperbus_cfg_seq
  import hyperbus_cfg_seq_pkg::*;
#(
  parameter int RegAddrWidth  = 32,
  parameter int RegDataWidth  = 32,
  parameter int NumEntries    = 4,
  parameter logic [NumEntries-1:0][RegAddrWidth-1:0] CfgAddrs = '0,
  parameter logic [NumEntries-1:0][RegDataWidth-1:0] CfgData  = '0,
  parameter int StartDelay    = 16,
  parameter int TimeoutCycles = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [RegAddrWidth-1:0]   host_req_addr_i,
  input  logic                      host_req_write_i,
  input  logic [RegDataWidth-1:0]   host_req_wdata_i,
  input  logic [RegDataWidth/8-1:0] host_req_wstrb_i,
  input  logic                      host_req_valid_i,
  output logic [RegDataWidth-1:0]   host_rsp_rdata_o,
  output logic                      host_rsp_ready_o,
  output logic                      host_rsp_error_o,
  output logic [RegAddrWidth-1:0]   dev_req_addr_o,
  output logic                      dev_req_write_o,
  output logic [RegDataWidth-1:0]   dev_req_wdata_o,
  output logic [RegDataWidth/8-1:0] dev_req_wstrb_o,
  output logic                      dev_req_valid_o,
  input  logic [RegDataWidth-1:0]   dev_rsp_rdata_i,
  input  logic                      dev_rsp_ready_i,
  input  logic                      dev_rsp_error_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [idx_width(NumEntries)-1:0] err_idx_o
);

  localparam int unsigned IdxWidth = idx_width(NumEntries);

  localparam logic [StateWidth-1:0] S_DELAY  = CFG_DELAY;
  localparam logic [StateWidth-1:0] S_WRITE  = CFG_WRITE;
  localparam logic [StateWidth-1:0] S_VERIFY = CFG_VERIFY;
  localparam logic [StateWidth-1:0] S_DONE   = CFG_DONE;
  localparam logic [StateWidth-1:0] S_ERR    = CFG_ERR;

  localparam logic [IdxWidth-1:0] LastIdx     = IdxWidth'(NumEntries - 1);
  localparam logic [31:0]         DelayLast   = 32'(StartDelay);
  localparam logic [31:0]         TimeoutLast = 32'(TimeoutCycles - 1);

  logic [StateWidth-1:0]   state;
  logic [31:0]             delay_cnt;
  logic [31:0]             timeout_cnt;
  logic [IdxWidth-1:0]     idx;
  logic [IdxWidth-1:0]     err_idx;
  logic                    start_pend;
  logic                    seq_valid;
  logic                    seq_write;
  logic [RegAddrWidth-1:0] seq_addr;
  logic [RegDataWidth-1:0] seq_wdata;
  logic                    pass_thru;

`ifdef HYPERBUS_CFG_SEQ_VERIFY_EN
  logic verify_bad;
  assign verify_bad = (dev_rsp_rdata_i != CfgData[idx]);
`endif

  assign pass_thru = (state == S_DONE) || (state == S_ERR);
  assign busy_o    = (state == S_DELAY) || (state == S_WRITE) || (state == S_VERIFY);
  assign done_o    = (state == S_DONE);
  assign err_o     = (state == S_ERR);
  assign err_idx_o = err_idx;

  // Sequencer FSM: start delay, one registered access per entry with a bubble
  // after each handshake, abort on device error / timeout / read-back mismatch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_DELAY;
      delay_cnt   <= '0;
      timeout_cnt <= '0;
      idx         <= '0;
      err_idx     <= '0;
      start_pend  <= 1'b0;
      seq_valid   <= 1'b0;
      seq_write   <= 1'b0;
      seq_addr    <= '0;
      seq_wdata   <= '0;
    end else begin
      case (state)
        S_DELAY: begin
          if (delay_cnt == DelayLast) begin
            // First access is launched straight out of the delay so its
            // valid rises StartDelay+1 cycles after the delay began.
            state       <= S_WRITE;
            seq_valid   <= 1'b1;
            seq_write   <= 1'b1;
            seq_addr    <= CfgAddrs[0];
            seq_wdata   <= CfgData[0];
            timeout_cnt <= '0;
          end else begin
            delay_cnt <= delay_cnt + 32'd1;
          end
        end
        S_WRITE, S_VERIFY: begin
          if (!seq_valid) begin
            seq_valid   <= 1'b1;
            seq_write   <= (state == S_WRITE);
            seq_addr    <= CfgAddrs[idx];
            seq_wdata   <= CfgData[idx];
            timeout_cnt <= '0;
          end else if (dev_rsp_ready_i) begin
            seq_valid <= 1'b0;
            if (dev_rsp_error_i) begin
              state   <= S_ERR;
              err_idx <= idx;
            end
`ifdef HYPERBUS_CFG_SEQ_VERIFY_EN
            else if (state == S_WRITE) begin
              state <= S_VERIFY;
            end else if (verify_bad) begin
              state   <= S_ERR;
              err_idx <= idx;
            end
`endif
            else if (idx == LastIdx) begin
              state <= S_DONE;
            end else begin
              idx   <= idx + IdxWidth'(1);
              state <= S_WRITE;
            end
          end else if (timeout_cnt == TimeoutLast) begin
            seq_valid <= 1'b0;
            state     <= S_ERR;
            err_idx   <= idx;
          end else begin
            timeout_cnt <= timeout_cnt + 32'd1;
          end
        end
        S_DONE, S_ERR: begin
          // A restart never cuts a host transfer: it waits for host valid low.
          if ((start_i || start_pend) && !host_req_valid_i) begin
            state      <= S_DELAY;
            delay_cnt  <= '0;
            idx        <= '0;
            err_idx    <= '0;
            start_pend <= 1'b0;
          end else if (start_i) begin
            start_pend <= 1'b1;
          end
        end
        default: state <= S_DELAY;
      endcase
    end
  end

  hyperbus_cfg_seq_mux #(
    .AddrWidth (RegAddrWidth),
    .DataWidth (RegDataWidth)
  ) u_mux (
    .pass_thru  (pass_thru),
    .seq_valid  (seq_valid),
    .seq_write  (seq_write),
    .seq_addr   (seq_addr),
    .seq_wdata  (seq_wdata),
    .host_addr  (host_req_addr_i),
    .host_write (host_req_write_i),
    .host_wdata (host_req_wdata_i),
    .host_wstrb (host_req_wstrb_i),
    .host_valid (host_req_valid_i),
    .host_rdata (host_rsp_rdata_o),
    .host_ready (host_rsp_ready_o),
    .host_error (host_rsp_error_o),
    .dev_addr   (dev_req_addr_o),
    .dev_write  (dev_req_write_o),
    .dev_wdata  (dev_req_wdata_o),
    .dev_wstrb  (dev_req_wstrb_o),
    .dev_valid  (dev_req_valid_o),
    .dev_rdata  (dev_rsp_rdata_i),
    .dev_ready  (dev_rsp_ready_i),
    .dev_error  (dev_rsp_error_i)
  );

endmodule
`default_nettype wire

// File: tb/tb_hyperbus_cfg_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hyperbus_cfg_seq
//  Purpose  : Self-checking bench for hyperbus_cfg_seq (3 entries, delay 4,
//             timeout 8). Expected device transactions are queued when a
//             sequence or host access is launched and popped on handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hyperbus_cfg_seq;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NE = 3;
  localparam int SD = 4;
  localparam int TO = 8;
  localparam logic [NE-1:0][AW-1:0] ADDRS = {32'h0000_0108, 32'h0000_0104, 32'h0000_0100};
  localparam logic [NE-1:0][DW-1:0] DATAS = {32'h0000_BEEF, 32'h0000_2222, 32'h0000_1111};
`ifdef HYPERBUS_CFG_SEQ_VERIFY_EN
  localparam int STEP = 4;
`else
  localparam int STEP = 2;
`endif

  logic          clk, rst, start;
  logic [AW-1:0] h_addr;
  logic          h_write, h_valid;
  logic [DW-1:0] h_wdata;
  logic [3:0]    h_wstrb;
  logic [DW-1:0] h_rdata;
  logic          h_ready, h_error;
  logic [AW-1:0] d_addr;
  logic          d_write, d_valid;
  logic [DW-1:0] d_wdata;
  logic [3:0]    d_wstrb;
  logic [DW-1:0] d_rdata;
  logic          d_ready, d_error;
  logic          busy, done, err;
  logic [1:0]    err_idx;

  hyperbus_cfg_seq #(
    .RegAddrWidth (AW), .RegDataWidth (DW), .NumEntries (NE),
    .CfgAddrs (ADDRS), .CfgData (DATAS),
    .StartDelay (SD), .TimeoutCycles (TO)
  ) dut (
    .clk_i (clk), .rst_i (rst), .start_i (start),
    .host_req_addr_i (h_addr), .host_req_write_i (h_write),
    .host_req_wdata_i (h_wdata), .host_req_wstrb_i (h_wstrb),
    .host_req_valid_i (h_valid),
    .host_rsp_rdata_o (h_rdata), .host_rsp_ready_o (h_ready),
    .host_rsp_error_o (h_error),
    .dev_req_addr_o (d_addr), .dev_req_write_o (d_write),
    .dev_req_wdata_o (d_wdata), .dev_req_wstrb_o (d_wstrb),
    .dev_req_valid_o (d_valid),
    .dev_rsp_rdata_i (d_rdata), .dev_rsp_ready_i (d_ready),
    .dev_rsp_error_i (d_error),
    .busy_o (busy), .done_o (done), .err_o (err), .err_idx_o (err_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Device model: word memory, optional stall on entry 1, error, corrupt read.
  logic [31:0] mem [0:63];
  logic dev_ready_en, stall_a1, dev_err_en, corrupt_a2;
  always_comb begin
    d_ready = dev_ready_en && !(stall_a1 && (d_addr == ADDRS[1]));
    d_error = dev_err_en;
    d_rdata = mem[d_addr[7:2]];
    if (corrupt_a2 && (d_addr == ADDRS[2])) d_rdata = 32'h0000_DEAD;
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } txn_t;
  txn_t expq[$];

  int cyc, checks, errors, a2_seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic wr, input logic [31:0] a, input logic [31:0] d, input int c);
    txn_t t;
    t.wr = wr; t.addr = a; t.data = d; t.cyc = c;
    expq.push_back(t);
  endtask

  // Expected device traffic of one full sequence whose delay starts at ref0.
  task automatic push_seq(input int ref0);
    for (int k = 0; k < NE; k++) begin
      push(1'b1, ADDRS[k], DATAS[k], ref0 + SD + 1 + STEP * k);
`ifdef HYPERBUS_CFG_SEQ_VERIFY_EN
      push(1'b0, ADDRS[k], 32'h0, ref0 + SD + 3 + STEP * k);
`endif
    end
  endtask

  // Runs mid-cycle: a handshake seen here completes at the next rising edge.
  task automatic monitor();
    txn_t e;
    if (d_valid && (d_addr == ADDRS[2])) a2_seen++;
    if (d_valid && d_ready) begin
      check("txn_expected", 64'(expq.size() != 0), 64'd1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        check("dev_write", 64'(d_write), 64'(e.wr));
        check("dev_addr", 64'(d_addr), 64'(e.addr));
        if (e.wr) begin
          check("dev_wdata", 64'(d_wdata), 64'(e.data));
          check("dev_wstrb", 64'(d_wstrb), 64'hF);
        end
        if (e.cyc >= 0) check("dev_cycle", 64'(cyc), 64'(e.cyc));
      end
      if (d_write && !d_error) mem[d_addr[7:2]] = d_wdata;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_term(output int at);
    int n;
    n = 0;
    while (!(done || err) && n < 200) begin
      tick();
      n++;
    end
    at = cyc;
    check("term_reached", 64'(done || err), 64'd1);
  endtask

  initial begin
    int at, rf, n;
    logic stall_ok;
    checks = 0; errors = 0; cyc = 0; a2_seen = 0;
    rst = 1'b1; start = 1'b0;
    h_addr = '0; h_write = 1'b0; h_wdata = '0; h_wstrb = '0; h_valid = 1'b0;
    dev_ready_en = 1'b1; stall_a1 = 1'b0; dev_err_en = 1'b0; corrupt_a2 = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_err_idx", 64'(err_idx), 64'd0);
    check("rst_dev_valid", 64'(d_valid), 64'd0);
    check("rst_host_ready", 64'(h_ready), 64'd0);
    check("rst_host_rdata", 64'(h_rdata), 64'd0);

    // Post-reset sequence with a host write stalled behind it
    rst = 1'b0; cyc = 0;
    push_seq(0);
    h_valid = 1'b1; h_write = 1'b1; h_addr = 32'h10; h_wdata = 32'h5A5A; h_wstrb = 4'hF;
    push(1'b1, 32'h10, 32'h5A5A, SD + STEP * NE);
    stall_ok = 1'b1; n = 0;
    while (!done && n < 200) begin
      if (h_ready) stall_ok = 1'b0;
      tick();
      n++;
    end
    check("host_stalled", 64'(stall_ok), 64'd1);
    check("done_cycle", 64'(cyc), 64'(SD + STEP * NE));
    check("done_busy", 64'(busy), 64'd0);
    check("done_flag", 64'(done), 64'd1);
    check("done_err", 64'(err), 64'd0);
    check("pass_ready_w", 64'(h_ready), 64'd1);
    tick();
    h_valid = 1'b0;

    // Zero-latency pass-through read
    h_valid = 1'b1; h_write = 1'b0; h_addr = ADDRS[1];
    push(1'b0, ADDRS[1], 32'h0, cyc);
    #1;
    check("pass_rdata", 64'(h_rdata), 64'(DATAS[1]));
    check("pass_ready_r", 64'(h_ready), 64'd1);
    check("pass_error", 64'(h_error), 64'd0);
    tick();
    h_valid = 1'b0;

    // start while host valid high: deferred until the host transfer ends
    dev_ready_en = 1'b0;
    h_valid = 1'b1; h_write = 1'b0; h_addr = ADDRS[0];
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pend_busy", 64'(busy), 64'd0);
      check("pend_done", 64'(done), 64'd1);
    end
    dev_ready_en = 1'b1;
    push(1'b0, ADDRS[0], 32'h0, cyc);
    tick();
    h_valid = 1'b0;
    rf = cyc + 1;
    push_seq(rf);
    tick();
    check("restart_busy", 64'(busy), 64'd1);
    check("restart_done", 64'(done), 64'd0);
    wait_term(at);
    check("rerun_done", 64'(done), 64'd1);
    check("rerun_cycle", 64'(at), 64'(rf + SD + STEP * NE));

    // Device error on entry 0
    dev_err_en = 1'b1;
    pulse_start();
    rf = cyc;
    push(1'b1, ADDRS[0], DATAS[0], rf + SD + 1);
    wait_term(at);
    check("derr_err", 64'(err), 64'd1);
    check("derr_done", 64'(done), 64'd0);
    check("derr_idx", 64'(err_idx), 64'd0);
    check("derr_cycle", 64'(at), 64'(rf + SD + 2));
    dev_err_en = 1'b0;

    // Timeout on entry 1; entry 2 must never be issued
    stall_a1 = 1'b1;
    pulse_start();
    check("restart_err_clr", 64'(err), 64'd0);
    rf = cyc;
    a2_seen = 0;
    push(1'b1, ADDRS[0], DATAS[0], rf + SD + 1);
`ifdef HYPERBUS_CFG_SEQ_VERIFY_EN
    push(1'b0, ADDRS[0], 32'h0, rf + SD + 3);
`endif
    wait_term(at);
    check("to_err", 64'(err), 64'd1);
    check("to_idx", 64'(err_idx), 64'd1);
    check("to_cycle", 64'(at), 64'(rf + SD + 1 + STEP + TO));
    check("to_no_entry2", 64'(a2_seen), 64'd0);
    stall_a1 = 1'b0;

`ifdef HYPERBUS_CFG_SEQ_VERIFY_EN
    // Read-back mismatch on entry 2
    corrupt_a2 = 1'b1;
    pulse_start();
    rf = cyc;
    push_seq(rf);
    wait_term(at);
    check("vfy_err", 64'(err), 64'd1);
    check("vfy_idx", 64'(err_idx), 64'd2);
    check("vfy_cycle", 64'(at), 64'(rf + SD + STEP * NE));
    corrupt_a2 = 1'b0;
`endif

    // Reset in the middle of a stalled access drops it
    dev_ready_en = 1'b0;
    pulse_start();
    check("restart_idx_clr", 64'(err_idx), 64'd0);
    n = 0;
    while (!d_valid && n < 50) begin
      tick();
      n++;
    end
    check("midrst_valid_seen", 64'(d_valid), 64'd1);
    rst = 1'b1;
    tick();
    check("midrst_valid", 64'(d_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    dev_ready_en = 1'b1;
    rf = cyc;
    push_seq(rf);
    wait_term(at);
    check("midrst_done", 64'(done), 64'd1);
    check("midrst_cycle", 64'(at), 64'(rf + SD + STEP * NE));

    check("queue_drained", 64'(expq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
